// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: registered-read, stream-loadable instruction memory for the fetch stage
module instr_fetch_mem #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 5,
  parameter int    PC_W      = 32,
  parameter int    BYTE_ADDR = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   inPC,
  input  logic              inFetch,
  input  logic              inStall,
  output logic [DATA_W-1:0] outInstruction,
  output logic              outValid,
  output logic              outFault,
  input  logic              inLoadStart,
  input  logic              inLoadValid,
  input  logic [DATA_W-1:0] inLoadData,
  input  logic              inLoadLast,
  output logic              outLoadReady,
  output logic              outLoadDone
);
  typedef enum logic {RUN, LOAD} state_t;
  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] cnt, idx;
  logic [PC_W-1:0]   word_pc;
  logic              bad, hs, last_word;
  assign outLoadReady = state == LOAD;
  always_comb begin
    word_pc   = BYTE_ADDR != 0 ? inPC >> 2 : inPC;
    idx       = word_pc[ADDR_W-1:0];
    bad       = (word_pc >> ADDR_W) != '0 || (BYTE_ADDR != 0 && inPC[1:0] != 2'b00);
    hs        = state == LOAD && inLoadValid;
    last_word = inLoadLast || cnt == '1;
    state_nxt = state == RUN ? (inLoadStart ? LOAD : RUN) : (hs && last_word ? RUN : LOAD);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      outLoadDone <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= state == RUN ? '0 : cnt + ADDR_W'(hs);
      outLoadDone <= hs && last_word;
    end
  end
  always_ff @(posedge clk) begin
    if (hs) mem[cnt] <= inLoadData;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outInstruction <= '0;
      outValid       <= 1'b0;
      outFault       <= 1'b0;
    end else if (state == LOAD) begin
      outInstruction <= '0;
      outValid       <= 1'b0;
      outFault       <= 1'b0;
    end else if (!inStall) begin
      outValid <= inFetch;
      outFault <= inFetch && bad;
      if (inFetch) outInstruction <= bad ? '0 : mem[idx];
    end
  end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: scoreboard bench for fetch, fault, stall and streaming load
module tb_instr_fetch_mem;
  logic        clk, reset;
  logic [31:0] inPC, outInstruction, inLoadData;
  logic        inFetch, inStall, outValid, outFault;
  logic        inLoadStart, inLoadValid, inLoadLast, outLoadReady, outLoadDone;
  int          tests, fails, done_seen, done_exp;
  logic [32:0] q [$];
  logic [31:0] ld [32];

  instr_fetch_mem dut (
    .clk(clk), .reset(reset), .inPC(inPC), .inFetch(inFetch), .inStall(inStall),
    .outInstruction(outInstruction), .outValid(outValid), .outFault(outFault),
    .inLoadStart(inLoadStart), .inLoadValid(inLoadValid), .inLoadData(inLoadData),
    .inLoadLast(inLoadLast), .outLoadReady(outLoadReady), .outLoadDone(outLoadDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei, input logic ef);
    inPC = pc;
    inFetch = 1'b1;
    inStall = 1'b0;
    q.push_back({ei, ef});
    step();
    inFetch = 1'b0;
  endtask

  task automatic stall(input int n, input logic [31:0] pc, input logic [31:0] ei, input logic ef);
    inStall = 1'b1;
    inFetch = 1'b1;
    inPC = pc;
    for (int i = 0; i < n; i++) begin
      q.push_back({ei, ef});
      step();
    end
    inStall = 1'b0;
    inFetch = 1'b0;
  endtask

  task automatic load_words(input int n, input bit last);
    inLoadStart = 1'b1;
    step();
    inLoadStart = 1'b0;
    chk("ready_on_entry", {31'd0, outLoadReady}, 32'd1);
    for (int i = 0; i < n; i++) begin
      inLoadValid = 1'b1;
      inLoadData = ld[i];
      inLoadLast = last && i == n - 1;
      step();
    end
    inLoadValid = 1'b0;
    inLoadLast = 1'b0;
  endtask

  task automatic check_done();
    done_exp++;
    chk("done_pulse", {31'd0, outLoadDone}, 32'd1);
    chk("ready_after_exit", {31'd0, outLoadReady}, 32'd0);
    step();
    chk("done_one_cycle", {31'd0, outLoadDone}, 32'd0);
  endtask

  // monitor: pop one expected fetch result for every cycle the DUT shows outValid
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (outValid) begin
          if (q.size() == 0) chk("unexpected_valid", {31'd0, outValid}, 32'd0);
          else begin
            e = q.pop_front();
            chk("fetch_instr", outInstruction, e[32:1]);
            chk("fetch_fault", {31'd0, outFault}, {31'd0, e[0]});
          end
        end
        if (outLoadDone) done_seen++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; inPC = '0; inFetch = 0; inStall = 0;
    inLoadStart = 0; inLoadValid = 0; inLoadData = '0; inLoadLast = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_instr", outInstruction, 32'd0);
    chk("rst_valid", {31'd0, outValid}, 32'd0);
    chk("rst_fault", {31'd0, outFault}, 32'd0);
    chk("rst_ready", {31'd0, outLoadReady}, 32'd0);
    chk("rst_done", {31'd0, outLoadDone}, 32'd0);
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 32; i++) ld[i] = 32'h100 + i;
    ld[2] = 32'h00221821;
    ld[31] = 32'hDEADBEEF;
    load_words(32, 1'b0);
    check_done();
    fetch(32'h8, 32'h00221821, 1'b0);
    stall(3, 32'hC, 32'h00221821, 1'b0);
    fetch(32'h6, 32'h0, 1'b1);
    fetch(32'h80, 32'h0, 1'b1);
    fetch(32'h1, 32'h0, 1'b1);
    fetch(32'h7C, 32'hDEADBEEF, 1'b0);
    fetch(32'h10, 32'h104, 1'b0);
    step();
    chk("idle_valid", {31'd0, outValid}, 32'd0);
    chk("idle_hold_instr", outInstruction, 32'h104);
    fetch(32'h14, 32'h105, 1'b0);
    #5 reset = 1'b1;
    #1;
    chk("async_rst_instr", outInstruction, 32'd0);
    chk("async_rst_valid", {31'd0, outValid}, 32'd0);
    reset = 1'b0;
    step();
    ld[0] = 32'h11; ld[1] = 32'h22; ld[2] = 32'h33;
    load_words(3, 1'b1);
    check_done();
    fetch(32'h0, 32'h11, 1'b0);
    fetch(32'h4, 32'h22, 1'b0);
    fetch(32'h8, 32'h33, 1'b0);
    fetch(32'hC, 32'h103, 1'b0);
    step();
    ld[0] = 32'hAA; ld[1] = 32'hBB;
    load_words(2, 1'b0);
    chk("ready_mid_load", {31'd0, outLoadReady}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, outLoadReady}, 32'd0);
    chk("abort_done", {31'd0, outLoadDone}, 32'd0);
    reset = 1'b0;
    step();
    fetch(32'h0, 32'hAA, 1'b0);
    fetch(32'h4, 32'hBB, 1'b0);
    fetch(32'h8, 32'h33, 1'b0);
    step();
    step();
    chk("queue_drained", q.size(), 32'd0);
    chk("done_count", done_seen, done_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
